// File: rtl/bist_pkg.sv
// Shared BIST definitions: checker FSM encoding, default MISR constants and
// the single-step MISR compaction function.
package bist_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HUNT    = 3'd1,
      S_DATA    = 3'd2,
      S_STOP    = 3'd3,
      S_COMPACT = 3'd4,
      S_CHECK   = 3'd5
   } chk_state_t;

   localparam logic [15:0] SEED_DEF    = 16'hFFFF;
   localparam logic [15:0] POLY_DEF    = 16'h1021;
   localparam int          TIMEOUT_DEF = 64;

   // One MISR step: shift left, fold in taps on MSB carry-out, xor the byte in.
   function automatic logic [15:0] misr_step(input logic [15:0] q,
                                             input logic [15:0] poly,
                                             input logic [7:0]  din);
      return {q[14:0], 1'b0} ^ (q[15] ? poly : 16'h0000) ^ {8'h00, din};
   endfunction

endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register; compacts one byte per enable.
module misr16
   import bist_pkg::*;
#(
   parameter logic [15:0] POLY = POLY_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        en,
   input  logic [15:0] seed,
   input  logic [7:0]  din,
   output logic [15:0] q
);

   logic [15:0] r_q;

   // Reset and load both restore the seed; load has priority over compaction.
   always_ff @(posedge clk) begin
      if (rst)       r_q <= seed;
      else if (load) r_q <= seed;
      else if (en)   r_q <= misr_step(r_q, POLY, din);
   end

   assign q = r_q;

endmodule

// File: rtl/misr_signature_checker.sv
// Receives the BIST UART stream (8N1, LSB first), compacts FRAMES bytes into
// a MISR and compares the result against the golden signature.
module misr_signature_checker
   import bist_pkg::*;
#(
   parameter int          FRAMES  = 4,
   parameter logic [15:0] SEED    = SEED_DEF,
   parameter logic [15:0] POLY    = POLY_DEF,
   parameter int          TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        start,
   input  logic        serial_in,
   input  logic [15:0] golden,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        fault,
   output logic        frame_err,
   output logic        timeout,
   output logic [15:0] signature
);

   localparam int HW = $clog2(TIMEOUT + 1);

   chk_state_t    r_state, w_next;
   logic [HW-1:0] r_hunt_cnt;
   logic [3:0]    r_bit_cnt;
   logic [7:0]    r_frame_cnt;
   logic [7:0]    r_data;
   logic          r_done, r_pass, r_fault, r_ferr, r_tmo;

   logic          w_load, w_en, w_abort, w_check, w_hunt_hit, w_last, w_pass;
   logic [15:0]   w_sig;

   // The tick that would make the idle count reach TIMEOUT aborts the run.
   assign w_hunt_hit = (r_hunt_cnt == HW'(TIMEOUT - 1));
   assign w_last     = ((r_frame_cnt + 8'd1) == 8'(FRAMES));
   assign w_pass     = (w_sig == golden) && !r_ferr;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; serial sampling only happens on tick.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = S_HUNT;
         S_HUNT:    if (tick) begin
                       if (!serial_in)      w_next = S_DATA;
                       else if (w_hunt_hit) w_next = S_IDLE;
                    end
         S_DATA:    if (tick && r_bit_cnt == 4'd7) w_next = S_STOP;
         S_STOP:    if (tick) w_next = S_COMPACT;
         S_COMPACT: w_next = w_last ? S_CHECK : S_HUNT;
         S_CHECK:   w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Per-state control strobes.
   always_comb begin
      w_load  = (r_state == S_IDLE) && start;
      w_en    = (r_state == S_COMPACT);
      w_abort = (r_state == S_HUNT) && tick && serial_in && w_hunt_hit;
      w_check = (r_state == S_CHECK);
   end

   // Datapath: counters, receive shifter and result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hunt_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_frame_cnt <= '0;
         r_data      <= '0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fault     <= 1'b0;
         r_ferr      <= 1'b0;
         r_tmo       <= 1'b0;
      end else begin
         r_done <= w_abort || w_check;
         case (r_state)
            S_IDLE: if (start) begin
               r_frame_cnt <= '0;
               r_hunt_cnt  <= '0;
               r_ferr      <= 1'b0;
               r_tmo       <= 1'b0;
               r_pass      <= 1'b0;
            end
            S_HUNT: if (tick) begin
               if (!serial_in) begin
                  r_hunt_cnt <= '0;
                  r_bit_cnt  <= '0;
               end else begin
                  r_hunt_cnt <= r_hunt_cnt + 1'b1;
                  if (w_hunt_hit) begin
                     r_tmo   <= 1'b1;
                     r_fault <= 1'b1;
                     r_pass  <= 1'b0;
                  end
               end
            end
            S_DATA: if (tick) begin
               r_data    <= {serial_in, r_data[7:1]};
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            S_STOP: if (tick && !serial_in) r_ferr <= 1'b1;
            S_COMPACT: begin
               r_frame_cnt <= r_frame_cnt + 1'b1;
               r_hunt_cnt  <= '0;
            end
            S_CHECK: begin
               r_pass  <= w_pass;
               r_fault <= r_fault | !w_pass;
            end
            default: ;
         endcase
      end
   end

   misr16 #(.POLY(POLY)) u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (w_load),
      .en   (w_en),
      .seed (SEED),
      .din  (r_data),
      .q    (w_sig)
   );

   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign pass      = r_pass;
   assign fault     = r_fault;
   assign frame_err = r_ferr;
   assign timeout   = r_tmo;
   assign signature = w_sig;

endmodule

// File: tb/tb_misr_signature_checker.sv
// Bench for misr_signature_checker: three instances (defaults, SEED=0/FRAMES=1,
// SEED=0/FRAMES=2) driven from a shared serial line, checked against a
// byte-list signature model.
module tb_misr_signature_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick = 1'b0;
   logic        serial_in = 1'b1;
   logic [15:0] golden = '0;
   logic [2:0]  start = '0;
   logic [2:0]  busy, done, pass, fault, ferr, tmo;
   logic [15:0] sig [3];
   int          done_cnt [3] = '{0, 0, 0};
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   misr_signature_checker u0 (
      .clk(clk), .rst(rst), .tick(tick), .start(start[0]), .serial_in(serial_in),
      .golden(golden), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fault(fault[0]),
      .frame_err(ferr[0]), .timeout(tmo[0]), .signature(sig[0]));

   misr_signature_checker #(.FRAMES(1), .SEED(16'h0000)) u1 (
      .clk(clk), .rst(rst), .tick(tick), .start(start[1]), .serial_in(serial_in),
      .golden(golden), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fault(fault[1]),
      .frame_err(ferr[1]), .timeout(tmo[1]), .signature(sig[1]));

   misr_signature_checker #(.FRAMES(2), .SEED(16'h0000)) u2 (
      .clk(clk), .rst(rst), .tick(tick), .start(start[2]), .serial_in(serial_in),
      .golden(golden), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .fault(fault[2]),
      .frame_err(ferr[2]), .timeout(tmo[2]), .signature(sig[2]));

   // Count done pulses per instance.
   always @(posedge clk)
      for (int k = 0; k < 3; k++)
         if (done[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference signature: polynomial division of the byte stream, written as
   // shift-and-reduce over a plain byte list.
   function automatic logic [15:0] model_sig(input logic [15:0] seed, input logic [7:0] b [$]);
      int unsigned s = seed;
      foreach (b[i]) begin
         s = s * 2;
         if (s >= 32'h10000) s = (s - 32'h10000) ^ 32'h1021;
         s = s ^ b[i];
      end
      return s[15:0];
   endfunction

   task automatic send_bit(input logic b);
      serial_in = b;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int nidle);
      repeat (nidle) send_bit(1'b1);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop_ok);
      serial_in = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_start(input int k);
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input int base);
      int n = 0;
      while (done_cnt[k] == base && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done_cnt[k], base + 1);
   endtask

   initial begin
      logic [7:0]  q [$];
      logic [15:0] exp_sig;
      logic        match;
      int          base, nt;

      // Reset with start asserted: rst wins.
      start[0] = 1'b1;
      repeat (3) @(negedge clk);
      start[0] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_sig",   sig[0], 16'hFFFF);
      chk("rst_flags", {busy[0], done[0], pass[0], fault[0], ferr[0], tmo[0]}, 0);
      chk("rst_sig1",  sig[1], 16'h0000);

      // SEED=0, FRAMES=1, byte 01 -> 0001, pass.
      golden = 16'h0001;
      base = done_cnt[1];
      do_start(1);
      chk("busy_on", busy[1], 1'b1);
      send_frame(8'h01, 1'b1, 2);
      chk("f1_sig", sig[1], 16'h0001);
      wait_done(1, base);
      chk("f1_pass", {pass[1], fault[1], ferr[1]}, 3'b100);
      chk("f1_busy_off", busy[1], 1'b0);

      // SEED=0, FRAMES=2, bytes 01,02 -> 0000, pass.
      golden = 16'h0000;
      base = done_cnt[2];
      do_start(2);
      send_frame(8'h01, 1'b1, 0);
      chk("f2_sig_a", sig[2], 16'h0001);
      send_frame(8'h02, 1'b1, 3);
      wait_done(2, base);
      chk("f2_sig", sig[2], 16'h0000);
      chk("f2_pass", pass[2], 1'b1);

      // Defaults: first byte 00 -> EFDF; golden mismatched -> fail, fault sticky.
      q = {};
      q.push_back(8'h00);
      for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
      exp_sig = model_sig(16'hFFFF, q);
      golden = exp_sig ^ 16'h0100;
      base = done_cnt[0];
      do_start(0);
      send_frame(q[0], 1'b1, 1);
      chk("d_sig_first", sig[0], 16'hEFDF);
      for (int i = 1; i < 4; i++) send_frame(q[i], 1'b1, int'($urandom_range(0, 4)));
      wait_done(0, base);
      chk("d_sig", sig[0], exp_sig);
      chk("d_fail", {pass[0], fault[0]}, 2'b01);

      // Back-to-back runs with zero start latency, random bytes and golden.
      for (int r = 0; r < 4; r++) begin
         q = {};
         for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
         exp_sig = model_sig(16'hFFFF, q);
         match = (r == 0) ? 1'b1 : 1'($urandom);
         golden = match ? exp_sig : exp_sig ^ 16'(1 << $urandom_range(0, 15));
         base = done_cnt[0];
         do_start(0);
         chk("r_busy", busy[0], 1'b1);
         for (int i = 0; i < 4; i++) begin
            send_frame(q[i], 1'b1, int'($urandom_range(0, 5)));
            if (i == 1) do_start(0);   // ignored mid-run
         end
         wait_done(0, base);
         chk("r_sig", sig[0], exp_sig);
         chk("r_pass_fault", {pass[0], fault[0], ferr[0], tmo[0]}, {match, 3'b100});
         repeat ($urandom_range(0, 3)) @(negedge clk);
         chk("r_hold", sig[0], exp_sig);
      end

      // Bad stop bit: frame_err, pass=0 even with matching golden.
      golden = 16'h0001;
      base = done_cnt[1];
      do_start(1);
      send_frame(8'h01, 1'b0, 0);
      wait_done(1, base);
      chk("fe_sig", sig[1], 16'h0001);
      chk("fe_flags", {ferr[1], pass[1], fault[1]}, 3'b101);

      // Idle line: abort after exactly 64 ticks.
      base = done_cnt[0];
      do_start(0);
      nt = 0;
      while (done_cnt[0] == base && nt < 100) begin
         send_bit(1'b1);
         nt++;
      end
      chk("to_ticks", nt, 64);
      chk("to_flags", {tmo[0], pass[0], fault[0], busy[0]}, 4'b1010);

      // Reset during DATA of frame 2, start in the same cycle.
      base = done_cnt[0];
      do_start(0);
      send_frame(8'($urandom), 1'b1, 0);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'($urandom));
      rst = 1'b1;
      start[0] = 1'b1;
      @(negedge clk);
      chk("mr_sig", sig[0], 16'hFFFF);
      chk("mr_flags", {busy[0], done[0], pass[0], fault[0], ferr[0], tmo[0]}, 0);
      rst = 1'b0;
      start[0] = 1'b0;
      for (int i = 0; i < 10; i++) send_bit(1'($urandom));
      chk("mr_no_done", done_cnt[0], base);
      chk("mr_idle", {busy[0], sig[0]}, {1'b0, 16'hFFFF});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/misr_signature_checker.md
MISR_SIGNATURE_CHECKER -- requirements
Module: misr_signature_checker

Interface
REQ-001 SHALL have parameter FRAMES, default 4, number of UART frames compacted per run (1..255).
REQ-002 SHALL have parameter SEED, default 16'hFFFF, MISR load value at run start.
REQ-003 SHALL have parameter POLY, default 16'h1021, MISR feedback taps.
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum ticks spent in HUNT before abort.
REQ-005 SHALL have port clk  in  1  system clock.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port tick  in  1  baud enable, one clk wide; all serial sampling occurs only on clk edges with tick=1.
REQ-008 SHALL have port start  in  1  one-clk pulse that begins a run.
REQ-009 SHALL have port serial_in  in  1  BIST serial stream from the transmitter: idle high, 8N1, LSB first.
REQ-010 SHALL have port golden  in  16  expected signature, sampled in CHECK.
REQ-011 SHALL have port busy  out  1  high from start acceptance until done.
REQ-012 SHALL have port done  out  1  one-clk pulse at end of run.
REQ-013 SHALL have port pass  out  1  result of the last run, valid from done until next start.
REQ-014 SHALL have port fault  out  1  sticky failure flag, cleared only by rst.
REQ-015 SHALL have port frame_err  out  1  sticky stop-bit error within the current run.
REQ-016 SHALL have port timeout  out  1  current run aborted in HUNT.
REQ-017 SHALL have port signature  out  16  current MISR contents.

Function
REQ-018 SHALL implement the FSM states IDLE, HUNT, DATA, STOP, COMPACT and CHECK.
REQ-019 IDLE: start=1 SHALL load SEED into the MISR, clear frame_cnt, frame_err, timeout and pass, set busy, and move to HUNT; a tick arriving in the same cycle is not sampled.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 HUNT: tick with serial_in=0 SHALL clear bit_cnt and the HUNT tick counter and move to DATA; tick with serial_in=1 SHALL increment the HUNT tick counter.
REQ-022 HUNT: when the HUNT tick counter reaches TIMEOUT, the block SHALL set timeout and fault, clear pass, pulse done, clear busy, and return to IDLE.
REQ-023 DATA: on each tick, serial_in SHALL be shifted into the data register LSB-first; after the 8th data tick the FSM SHALL move to STOP.
REQ-024 STOP: on a tick with serial_in=0, frame_err SHALL be set; on any tick the FSM SHALL move to COMPACT, so the data byte is compacted in either case.
REQ-025 COMPACT: exactly one clk, tick not required: misr <= {misr[14:0],1'b0} ^ (misr[15] ? POLY : 0) ^ {8'h00,data}; frame_cnt SHALL increment.
REQ-026 COMPACT: if the incremented frame_cnt equals FRAMES the FSM SHALL move to CHECK, otherwise to HUNT with the HUNT tick counter cleared.
REQ-027 CHECK: exactly one clk: pass <= (misr==golden) && !frame_err; fault <= fault | !pass_value; done pulses; busy clears; next state is IDLE.
REQ-028 signature SHALL hold its value in IDLE until the next start.
REQ-029 frame_cnt SHALL be 8 bits wide and bit_cnt 4 bits wide; the HUNT counter SHALL be sized by $clog2(TIMEOUT+1).
REQ-030 done-to-start latency SHALL be 0: a start pulse in the cycle after done is accepted.

Reset
REQ-031 rst SHALL win over every other input, including start in the same cycle.
REQ-032 Reset SHALL force the FSM to IDLE; signature=SEED; busy, done, pass, fault, frame_err, timeout = 0; all counters 0.
REQ-033 rst asserted mid-run SHALL abort the run with no done pulse.

Structure
REQ-034 The state encoding and the default constants SEED, POLY and TIMEOUT SHALL reside in the shared package bist_pkg.
REQ-035 The MISR register and its update SHALL be one sub-module, misr16, with inputs clk, rst, load, en, seed and din[7:0] and output q[15:0].
REQ-036 The block SHALL sit downstream of the tx serial output in BIST mode and SHALL replace the bit-by-bit comparator.

Verification
REQ-037 SEED=0, FRAMES=1: send byte 8'h01 with a valid frame -> signature=16'h0001; golden=16'h0001 -> done with pass=1, fault=0.
REQ-038 SEED=0, FRAMES=2: send bytes 8'h01 then 8'h02 -> signature=16'h0000; golden=16'h0000 -> pass=1.
REQ-039 Defaults: send 4 frames, the first of them 8'h00 -> signature after the first compaction = 16'hEFDF; golden mismatched -> pass=0, fault=1, and fault stays 1 through a following passing run.
REQ-040 FRAMES=1: frame 8'h01 with its stop bit held 0 -> frame_err=1, signature=16'h0001 (SEED=0), pass=0 despite golden matching.
REQ-041 serial_in held at 1 after start -> done pulses after exactly 64 ticks with timeout=1, pass=0, fault=1.
REQ-042 rst during DATA of frame 2 -> no done pulse, and all outputs at reset values on the next clk; start in the same cycle as rst -> stays IDLE.
